noc_input_port: RTL and testbench

- Input stage of a NoC router port, sitting directly upstream of the router controller.
- Accepts flits from the inter-router link under credit-based flow control and stores them in a small FIFO.
- Decodes the XY route from each head flit and locks that route for the rest of the packet.
- Presents one flit at a time to the controller with a valid/ready handshake, plus a buffer-pressure flag.

---
 rtl/noc_input_port.sv | 175 +++++++++++++++++
 tb/tb_noc_input_port.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_input_port.sv
// rtl/noc_input_port.sv - NoC router input port: credit FIFO, XY route lock, controller handshake (optional NOC_IN_STATS_EN adds pkt_count)
module noc_input_port #(
  parameter int FLIT_W  = 32,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 2,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              link_valid,
  input  logic [FLIT_W-1:0] link_flit,
  output logic              link_credit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_head,
  output logic              out_tail,
  output logic [2:0]        dest_port,
  output logic              buffer_full,
  output logic              err_overflow,
  output logic              err_proto
`ifdef NOC_IN_STATS_EN
  ,
  output logic [15:0]       pkt_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
  localparam logic [COORD_W-1:0] LX = COORD_W'(LOCAL_X);
  localparam logic [COORD_W-1:0] LY = COORD_W'(LOCAL_Y);

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_EAST  = 3'd1;
  localparam logic [2:0] PORT_WEST  = 3'd2;
  localparam logic [2:0] PORT_NORTH = 3'd3;
  localparam logic [2:0] PORT_SOUTH = 3'd4;

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2:0]        route_q;
  logic              credit_q, err_overflow_q, err_proto_q;

  logic [FLIT_W-1:0]  head_flit;
  logic               nonempty, hd_is_head, hd_is_tail;
  logic [COORD_W-1:0] dest_x, dest_y;
  logic [2:0]         route_c;
  logic               discard, handshake, pop_en, push_en;

  // Type bit 0 marks a packet start (head / head-tail), bit 1 marks a packet end (tail / head-tail)
  assign head_flit  = mem_q[rd_ptr_q];
  assign nonempty   = (count_q != '0);
  assign hd_is_head = head_flit[FLIT_W-2];
  assign hd_is_tail = head_flit[FLIT_W-1];
  assign dest_x     = head_flit[2*COORD_W-1:COORD_W];
  assign dest_y     = head_flit[COORD_W-1:0];

  // Dimension-ordered XY route of the flit currently at the FIFO head
  always_comb begin
    route_c = PORT_LOCAL;
    if (dest_x > LX)      route_c = PORT_EAST;
    else if (dest_x < LX) route_c = PORT_WEST;
    else if (dest_y > LY) route_c = PORT_NORTH;
    else if (dest_y < LY) route_c = PORT_SOUTH;
  end

  // Route FSM outputs: present legal flits, discard illegal ones, drive the route
  always_comb begin
    out_valid = 1'b0;
    discard   = 1'b0;
    dest_port = route_q;
    out_flit  = '0;
    out_head  = 1'b0;
    out_tail  = 1'b0;
    case (state_q)
      S_IDLE: begin
        out_valid = nonempty && hd_is_head;
        discard   = nonempty && !hd_is_head;
        if (out_valid) dest_port = route_c;
      end
      S_LOCKED: begin
        out_valid = nonempty && !hd_is_head;
        discard   = nonempty && hd_is_head;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
    if (out_valid) begin
      out_flit = head_flit;
      out_head = hd_is_head;
      out_tail = hd_is_tail;
    end
  end

  assign handshake = out_valid && out_ready;
  assign pop_en    = handshake || discard;
  // A full FIFO still takes a flit when a slot frees up in the same cycle
  assign push_en   = link_valid && ((count_q != FULL_CNT) || pop_en);

  // Route FSM next state: a head opens a packet, a tail closes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (handshake && hd_is_head && !hd_is_tail) state_d = S_LOCKED;
      S_LOCKED: if (handshake && hd_is_tail) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Route FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FIFO pointer and occupancy next state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = push_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_en  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_en && !pop_en)      count_d = count_q + CNT_W'(1);
    else if (!push_en && pop_en) count_d = count_q - CNT_W'(1);
  end

  // FIFO storage, no reset needed: contents are only read when counted valid
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= link_flit;
  end

  // FIFO control, latched route, credit return and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      route_q        <= PORT_LOCAL;
      credit_q       <= 1'b0;
      err_overflow_q <= 1'b0;
      err_proto_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= pop_en;
      if (state_q == S_IDLE && handshake) route_q <= route_c;
      if (link_valid && !push_en) err_overflow_q <= 1'b1;
      if (discard) err_proto_q <= 1'b1;
    end
  end

  assign link_credit  = credit_q;
  assign buffer_full  = (count_q == FULL_CNT);
  assign err_overflow = err_overflow_q;
  assign err_proto    = err_proto_q;

`ifdef NOC_IN_STATS_EN
  logic [15:0] pkt_count_q;

  // Delivered packet counter, wraps at 16 bits
  always_ff @(posedge clk) begin
    if (reset)                        pkt_count_q <= '0;
    else if (handshake && hd_is_tail) pkt_count_q <= pkt_count_q + 16'd1;
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// tb/tb_noc_input_port.sv - self-checking bench for noc_input_port against a queue-based packet model
module tb_noc_input_port;

  localparam int FLIT_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              link_valid;
  logic [FLIT_W-1:0] link_flit;
  logic              link_credit;
  logic              out_valid;
  logic              out_ready;
  logic [FLIT_W-1:0] out_flit;
  logic              out_head;
  logic              out_tail;
  logic [2:0]        dest_port;
  logic              buffer_full;
  logic              err_overflow;
  logic              err_proto;
`ifdef NOC_IN_STATS_EN
  logic [15:0]       pkt_count;
`endif

  noc_input_port #(
    .FLIT_W(FLIT_W), .DEPTH(DEPTH), .COORD_W(2), .LOCAL_X(1), .LOCAL_Y(1)
  ) dut (
    .clk(clk), .reset(reset), .link_valid(link_valid), .link_flit(link_flit),
    .link_credit(link_credit), .out_valid(out_valid), .out_ready(out_ready),
    .out_flit(out_flit), .out_head(out_head), .out_tail(out_tail),
    .dest_port(dest_port), .buffer_full(buffer_full),
    .err_overflow(err_overflow), .err_proto(err_proto)
`ifdef NOC_IN_STATS_EN
    , .pkt_count(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  // flits: type in [31:30], dest_x in [3:2], dest_y in [1:0]
  localparam logic [31:0] H30  = 32'h4000_000C;
  localparam logic [31:0] H01  = 32'h4000_0001;
  localparam logic [31:0] HT11 = 32'hC000_0005;
  localparam logic [31:0] BODY = 32'h0000_1230;
  localparam logic [31:0] TAIL = 32'h8000_0456;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_q[$];
  bit          m_in_pkt;
  logic [2:0]  m_route;
  bit          m_credit, m_ovf, m_proto;
  logic [15:0] m_pkts;
  bit          gen_in_pkt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] xy_route(input logic [31:0] f);
    int dx, dy;
    dx = int'(f[3:2]);
    dy = int'(f[1:0]);
    if (dx > 1) return 3'd1;
    if (dx < 1) return 3'd2;
    if (dy > 1) return 3'd3;
    if (dy < 1) return 3'd4;
    return 3'd0;
  endfunction

  function automatic bit starts_pkt(input logic [31:0] f);
    return f[31:30] == 2'b01 || f[31:30] == 2'b11;
  endfunction

  function automatic bit ends_pkt(input logic [31:0] f);
    return f[31:30] == 2'b10 || f[31:30] == 2'b11;
  endfunction

  // A flit is deliverable when it matches the packet grammar: starters outside a packet, continuations inside
  function automatic bit m_valid();
    if (m_q.size() == 0) return 1'b0;
    return m_in_pkt ? !starts_pkt(m_q[0]) : starts_pkt(m_q[0]);
  endfunction

  task automatic model_update(input bit lv, input logic [31:0] f, input bit rdy, input bit rst);
    bit v, disc, pop, acc;
    if (rst) begin
      m_q.delete();
      m_in_pkt = 0; m_credit = 0; m_ovf = 0; m_proto = 0; m_pkts = '0;
      return;
    end
    v    = m_valid();
    disc = (m_q.size() > 0) && !v;
    pop  = (v && rdy) || disc;
    acc  = lv && (m_q.size() < DEPTH || pop);
    if (lv && !acc) m_ovf = 1;
    if (disc) m_proto = 1;
    if (v && rdy) begin
      if (!m_in_pkt) m_route = xy_route(m_q[0]);
      if (m_q[0][31:30] == 2'b01) m_in_pkt = 1;
      else if (m_q[0][31:30] == 2'b10) m_in_pkt = 0;
      if (ends_pkt(m_q[0])) m_pkts = m_pkts + 16'd1;
    end
    m_credit = pop;
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(f);
  endtask

  task automatic compare_all();
    bit ev;
    ev = m_valid();
    chk("out_valid", out_valid, ev);
    chk("buffer_full", buffer_full, m_q.size() == DEPTH);
    chk("link_credit", link_credit, m_credit);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_proto", err_proto, m_proto);
`ifdef NOC_IN_STATS_EN
    chk("pkt_count", pkt_count, m_pkts);
`endif
    if (ev) begin
      chk("out_flit", out_flit, m_q[0]);
      chk("out_head", out_head, starts_pkt(m_q[0]));
      chk("out_tail", out_tail, ends_pkt(m_q[0]));
      chk("dest_port", dest_port, m_in_pkt ? m_route : xy_route(m_q[0]));
    end
  endtask

  // Drive one cycle at the falling edge, advance the model, check on the next falling edge
  task automatic step(input bit lv, input logic [31:0] f, input bit rdy, input bit rst);
    link_valid = lv; link_flit = f; out_ready = rdy; reset = rst;
    model_update(lv, f, rdy, rst);
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [31:0] gen_flit();
    logic [1:0]  t;
    logic [29:0] pay;
    pay = 30'($urandom);
    if ($urandom_range(0, 15) == 0) t = 2'($urandom);
    else if (!gen_in_pkt) t = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'b01;
    else t = ($urandom_range(0, 2) == 0) ? 2'b10 : 2'b00;
    if (t == 2'b01) gen_in_pkt = 1;
    else if (t == 2'b10 || t == 2'b11) gen_in_pkt = 0;
    return {t, pay};
  endfunction

  initial begin
    int rdy_pct, lv_pct;
    reset = 1'b1; link_valid = 1'b0; link_flit = '0; out_ready = 1'b0;
    m_route = '0; gen_in_pkt = 0;
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dest_port", dest_port, 0);
    chk("rst_buffer_full", buffer_full, 0);
    chk("rst_errs", {err_overflow, err_proto, link_credit}, 0);

    // 4-flit packet east, streaming
    step(1, H30, 1, 0);
    chk("t1_first_valid", out_valid, 1);
    chk("t1_route_head", dest_port, 3'd1);
    step(1, BODY, 1, 0);
    chk("t1_credit_head", link_credit, 1);
    chk("t1_route_body", dest_port, 3'd1);
    step(1, BODY, 1, 0);
    step(1, TAIL, 1, 0);
    chk("t1_route_tail", dest_port, 3'd1);
    step(0, '0, 1, 0);
    chk("t1_credit_tail", link_credit, 1);
    chk("t1_drained", out_valid, 0);
    step(0, '0, 1, 0);

    // overflow with the controller stalled, then drain
    step(1, H30, 0, 0);
    step(1, BODY, 0, 0);
    step(1, BODY, 0, 0);
    step(1, BODY, 0, 0);
    chk("t2_full", buffer_full, 1);
    step(1, BODY, 0, 0);
    chk("t2_overflow", err_overflow, 1);
    repeat (5) step(0, '0, 1, 0);

    // full FIFO with simultaneous push and pop
    step(0, '0, 0, 1);
    chk("t3_ovf_cleared", err_overflow, 0);
    step(1, H30, 0, 0);
    repeat (3) step(1, BODY, 0, 0);
    step(1, BODY, 1, 0);
    chk("t3_still_full", buffer_full, 1);
    chk("t3_no_overflow", err_overflow, 0);
    step(1, TAIL, 1, 0);
    repeat (5) step(0, '0, 1, 0);

    // orphan body while idle
    step(1, BODY, 0, 0);
    chk("t4_no_valid", out_valid, 0);
    step(0, '0, 0, 0);
    chk("t4_proto", err_proto, 1);
    chk("t4_credit", link_credit, 1);
    step(0, '0, 0, 0);

    // single-flit packet to local, then an independent head west
    step(1, HT11, 1, 0);
    chk("t5_valid", out_valid, 1);
    chk("t5_local", dest_port, 3'd0);
    chk("t5_head_tail", {out_head, out_tail}, 2'b11);
    step(1, H01, 1, 0);
    chk("t5_next_valid", out_valid, 1);
    chk("t5_west", dest_port, 3'd2);
    step(1, TAIL, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // reset with a partial packet buffered
    step(1, H30, 0, 0);
    step(1, BODY, 0, 0);
    step(0, '0, 0, 1);
    chk("t6_valid", out_valid, 0);
    chk("t6_full", buffer_full, 0);
    chk("t6_errs", {err_overflow, err_proto}, 0);

    // randomized traffic with shifting pressure and occasional resets
    rdy_pct = 70; lv_pct = 60;
    gen_in_pkt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        rdy_pct = $urandom_range(5, 100);
        lv_pct  = $urandom_range(20, 100);
      end
      if ($urandom_range(0, 499) == 0) begin
        gen_in_pkt = 0;
        step(0, '0, 0, 1);
      end else if ($urandom_range(0, 99) < lv_pct) begin
        step(1, gen_flit(), $urandom_range(0, 99) < rdy_pct, 0);
      end else begin
        step(0, 32'($urandom), $urandom_range(0, 99) < rdy_pct, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
